// File: rtl/clk_div_prog_pkg.sv
// Shared constants for the programmable clock divider.
`timescale 1ns/1ps
package clk_div_prog_pkg;
   localparam int unsigned CNT_W_DEF     = 8;
   localparam int unsigned DEF_RATIO_DEF = 15;
   localparam int unsigned MIN_RATIO     = 2;
endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between the divider and its user.
`timescale 1ns/1ps
interface clk_div_prog_if
   import clk_div_prog_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             en;
   logic [CNT_W-1:0] ratio_in;
   logic             ratio_ld;
   logic             clk_div;
   logic             tick;
   logic             active;
   logic             pend;
   logic             err;

   modport master (
      output en, ratio_in, ratio_ld,
      input  clk_div, tick, active, pend, err
   );

   modport slave (
      input  en, ratio_in, ratio_ld,
      output clk_div, tick, active, pend, err
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Period counter, shadow/active ratio, pend/err flags and start/stop control.
`timescale 1ns/1ps
module clk_div_ctrl
   import clk_div_prog_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DEF_RATIO = DEF_RATIO_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] ratio_in,
   input  logic             ratio_ld,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic [CNT_W-1:0] ratio_nxt,
   output logic             run_nxt,
   output logic             ratio_odd,
   output logic             tick,
   output logic             active,
   output logic             pend,
   output logic             err
);
   localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_RATIO);
   localparam logic [CNT_W-1:0] MIN_R = CNT_W'(MIN_RATIO);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ratio_q, ratio_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;
   logic             active_q, active_d;
   logic             tick_q, tick_d;
   logic             boundary;
   logic             legal;
   logic             load_ok;

   always_comb begin
      boundary = active_q && (cnt_q == ratio_q - CNT_W'(1));
      legal    = (ratio_in >= MIN_R);
      load_ok  = ratio_ld && legal;
      cnt_d    = cnt_q;
      ratio_d  = ratio_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      active_d = active_q;
      err_d    = err_q | (ratio_ld & ~legal);
      if (!active_q) begin
         // Idle: loads go straight to the active ratio, counter parked at 0.
         active_d = en;
         cnt_d    = '0;
         if (load_ok) begin
            ratio_d  = ratio_in;
            shadow_d = ratio_in;
            pend_d   = 1'b0;
         end
      end else if (boundary) begin
         active_d = en;
         cnt_d    = '0;
         if (load_ok) begin
            ratio_d  = ratio_in;
            shadow_d = ratio_in;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            ratio_d = shadow_q;
            pend_d  = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (load_ok) begin
            shadow_d = ratio_in;
            pend_d   = 1'b1;
         end
      end
      tick_d = active_d && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         ratio_q  <= DEF_R;
         shadow_q <= DEF_R;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ratio_q  <= ratio_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         active_q <= active_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      cnt_nxt   = cnt_d;
      ratio_nxt = ratio_d;
      run_nxt   = active_d;
      ratio_odd = ratio_q[0];
      tick      = tick_q;
      active    = active_q;
      pend      = pend_q;
      err       = err_q;
   end
endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider; odd ratios use a falling-edge retime flop.
`timescale 1ns/1ps
module clk_div_prog
   import clk_div_prog_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DEF_RATIO = DEF_RATIO_DEF
) (
   input  logic           clk,
   input  logic           rst,
   clk_div_prog_if.slave  bus
);
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] ratio_nxt;
   logic [CNT_W-1:0] half_nxt;
   logic             run_nxt;
   logic             ratio_odd;
   logic             q_p_q, q_p_d;
   logic             q_n_q, q_n_d;

   clk_div_ctrl #(
      .CNT_W     (CNT_W),
      .DEF_RATIO (DEF_RATIO)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .ratio_in  (bus.ratio_in),
      .ratio_ld  (bus.ratio_ld),
      .cnt_nxt   (cnt_nxt),
      .ratio_nxt (ratio_nxt),
      .run_nxt   (run_nxt),
      .ratio_odd (ratio_odd),
      .tick      (bus.tick),
      .active    (bus.active),
      .pend      (bus.pend),
      .err       (bus.err)
   );

   // High phase spans ceil(N/2) counts of the period that the next count belongs to.
   always_comb begin
      half_nxt = (ratio_nxt >> 1) + CNT_W'(ratio_nxt[0]);
      q_p_d    = run_nxt && (cnt_nxt < half_nxt);
      q_n_d    = rst ? 1'b0 : q_p_q;
   end

   always_ff @(posedge clk) begin
      if (rst) q_p_q <= 1'b0;
      else     q_p_q <= q_p_d;
   end

   always_ff @(negedge clk) begin
      q_n_q <= q_n_d;
   end

   // Odd N: AND with the half-cycle-late copy trims half a cycle off the high phase.
   always_comb begin
      bus.clk_div = ratio_odd ? (q_p_q & q_n_q) : q_p_q;
   end
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
`timescale 1ns/1ps
module tb_clk_div_prog;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   n_rise;
   int   n_tick;
   logic pend_seen;
   time  rise_t, prev_rise_t, fall_t, tick_t, prev_tick_t;

   clk_div_prog_if #(.CNT_W(8)) bus ();

   clk_div_prog #(
      .CNT_W     (8),
      .DEF_RATIO (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      n_rise = 0; n_tick = 0; pend_seen = 1'b0;
      rise_t = 0; prev_rise_t = 0; fall_t = 0; tick_t = 0; prev_tick_t = 0;
   end

   always @(posedge bus.clk_div) begin
      prev_rise_t = rise_t;
      rise_t      = $time;
      n_rise      = n_rise + 1;
   end
   always @(negedge bus.clk_div) fall_t = $time;
   always @(posedge bus.tick) begin
      prev_tick_t = tick_t;
      tick_t      = $time;
   end
   always @(negedge clk) begin
      if (bus.tick === 1'b1) n_tick = n_tick + 1;
      if (bus.pend === 1'b1) pend_seen = 1'b1;
   end

   function automatic int b(input logic v);
      return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : -1);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input string tag, input int max);
      int i;
      i = 0;
      do begin
         cyc(1);
         i++;
      end while (bus.tick !== 1'b1 && i < max);
      chk(tag, b(bus.tick), 1);
   endtask

   task automatic wait_rises(input string tag, input int k, input int max);
      int start;
      int i;
      start = n_rise;
      i = 0;
      while (n_rise < start + k && i < max) begin
         cyc(1);
         i++;
      end
      chk(tag, n_rise - start, k);
   endtask

   int snap_r, snap_t;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.ratio_in = '0;
      bus.ratio_ld = 1'b0;

      // Reset values
      cyc(3);
      chk("rst_clk_div", b(bus.clk_div), 0);
      chk("rst_tick",    b(bus.tick),    0);
      chk("rst_active",  b(bus.active),  0);
      chk("rst_pend",    b(bus.pend),    0);
      chk("rst_err",     b(bus.err),     0);
      rst = 1'b0;
      snap_t = n_tick;
      cyc(4);
      chk("idle_active", b(bus.active), 0);
      chk("idle_ticks",  n_tick - snap_t, 0);

      // Default N=15
      bus.en = 1'b1;
      cyc(1);
      chk("start_active", b(bus.active), 1);
      chk("start_tick",   b(bus.tick),   1);
      wait_rises("n15_rises", 2, 40);
      chk("n15_period", int'(rise_t - prev_rise_t), 300);
      chk("n15_high",   int'(fall_t - prev_rise_t), 150);
      snap_t = n_tick;
      cyc(45);
      chk("n15_ticks_45cyc", n_tick - snap_t, 3);

      // Illegal ratios
      bus.ratio_in = 8'd1; bus.ratio_ld = 1'b1;
      cyc(1);
      bus.ratio_in = 8'd0;
      cyc(1);
      bus.ratio_ld = 1'b0;
      cyc(1);
      chk("illegal_err",  b(bus.err),  1);
      chk("illegal_pend", b(bus.pend), 0);
      wait_rises("illegal_rises", 2, 40);
      chk("illegal_period", int'(rise_t - prev_rise_t), 300);

      // Mid-period load of N=4
      wait_rises("ld4_sync", 1, 40);
      bus.ratio_in = 8'd4; bus.ratio_ld = 1'b1;
      cyc(1);
      bus.ratio_ld = 1'b0;
      chk("ld4_pend_set", b(bus.pend), 1);
      cyc(5);
      chk("ld4_pend_hold", b(bus.pend), 1);
      wait_tick("ld4_boundary", 20);
      chk("ld4_pend_clr",   b(bus.pend), 0);
      chk("ld4_old_period", int'(tick_t - prev_tick_t), 300);
      wait_rises("ld4_rises", 2, 20);
      chk("n4_period", int'(rise_t - prev_rise_t), 80);
      chk("n4_high",   int'(fall_t - prev_rise_t), 40);

      // Load N=2 in the boundary cycle
      wait_tick("ld2_sync", 10);
      cyc(3);
      pend_seen = 1'b0;
      bus.ratio_in = 8'd2; bus.ratio_ld = 1'b1;
      cyc(1);
      bus.ratio_ld = 1'b0;
      chk("ld2_tick",       b(bus.tick), 1);
      chk("ld2_pend",       b(bus.pend), 0);
      chk("ld2_old_period", int'(tick_t - prev_tick_t), 80);
      wait_rises("ld2_rises", 2, 10);
      chk("n2_period", int'(rise_t - prev_rise_t), 40);
      chk("n2_high",   int'(fall_t - prev_rise_t), 20);
      cyc(3);
      chk("ld2_pend_never", b(pend_seen), 0);

      // N=7, stop requested at cnt=3
      bus.ratio_in = 8'd7; bus.ratio_ld = 1'b1;
      cyc(1);
      bus.ratio_ld = 1'b0;
      wait_tick("n7_sync", 10);
      chk("n7_pend", b(bus.pend), 0);
      cyc(3);
      bus.en = 1'b0;
      cyc(3);
      chk("stop_active_hold", b(bus.active), 1);
      cyc(1);
      chk("stop_active_off", b(bus.active), 0);
      chk("stop_clk_div",    b(bus.clk_div), 0);
      chk("stop_high",       int'(fall_t - rise_t), 70);
      snap_r = n_rise;
      snap_t = n_tick;
      cyc(20);
      chk("stop_no_rise", n_rise - snap_r, 0);
      chk("stop_no_tick", n_tick - snap_t, 0);

      // Idle load of N=15, then restart
      bus.ratio_in = 8'd15; bus.ratio_ld = 1'b1;
      cyc(1);
      bus.ratio_ld = 1'b0;
      chk("idle_ld_pend", b(bus.pend), 0);
      bus.en = 1'b1;
      cyc(1);
      chk("restart_tick", b(bus.tick), 1);
      wait_rises("idle_ld_rises", 2, 40);
      chk("idle_ld_period", int'(rise_t - prev_rise_t), 300);

      // Reset during the high phase
      cyc(1);
      chk("prerst_clk_div", b(bus.clk_div), 1);
      chk("prerst_err",     b(bus.err),     1);
      rst = 1'b1;
      cyc(1);
      chk("midrst_clk_div", b(bus.clk_div), 0);
      chk("midrst_active",  b(bus.active),  0);
      chk("midrst_err",     b(bus.err),     0);
      rst = 1'b0;
      bus.en = 1'b0;
      cyc(5);
      chk("postrst_idle", b(bus.active), 0);
      bus.en = 1'b1;
      cyc(1);
      chk("postrst_tick", b(bus.tick), 1);
      wait_rises("postrst_rises", 2, 40);
      chk("postrst_period", int'(rise_t - prev_rise_t), 300);
      chk("postrst_high",   int'(fall_t - prev_rise_t), 150);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
